// File: rtl/mips_cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, instruction width and the
// default boot address used by the fetch unit.
package mips_cpu_pkg;

    localparam int INSTRUCTION_WIDTH = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD,
        HALTED
    } fetch_state_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] address);
        return {address[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the instruction-memory read bus, the decode handshake and the
// redirect input of the fetch unit. The master side is the fetch unit.
interface instruction_fetch_unit_if;
    import mips_cpu_pkg::*;

    logic [31:0]                  avm_address;
    logic                         avm_read;
    logic                         avm_waitrequest;
    logic [INSTRUCTION_WIDTH-1:0] avm_readdata;

    logic [INSTRUCTION_WIDTH-1:0] instruction;
    logic                         instruction_valid;
    logic                         instruction_ready;
    logic [31:0]                  program_counter;

    logic                         redirect;
    logic [31:0]                  redirect_target;
    logic                         active;

    modport master (
        output avm_address, avm_read, instruction, instruction_valid,
               program_counter, active,
        input  avm_waitrequest, avm_readdata, instruction_ready,
               redirect, redirect_target
    );

    modport slave (
        input  avm_address, avm_read, instruction, instruction_valid,
               program_counter, active,
        output avm_waitrequest, avm_readdata, instruction_ready,
               redirect, redirect_target
    );

endinterface

// File: rtl/instruction_fetch_unit_pc.sv
// fetch_pc_register: holds the current fetch address and a pending
// redirect (delay-slot target), and works out the address that follows the
// instruction being handed off.
module fetch_pc_register
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] fetch_address,
    output logic        halt_next
);

    logic        pending;
    logic [31:0] pending_target;
    logic [31:0] next_address;
    logic        by_redirect;

    // Next address: a redirect seen this cycle beats a stored one, otherwise
    // step sequentially with natural 32-bit wrap.
    always_comb begin
        next_address = fetch_address + 32'd4;
        by_redirect  = 1'b0;
        if (redirect_valid) begin
            next_address = word_align(redirect_target);
            by_redirect  = 1'b1;
        end else if (pending) begin
            next_address = pending_target;
            by_redirect  = 1'b1;
        end
        halt_next = by_redirect && (next_address == 32'd0);
    end

    // Advance on handoff (consuming any pending target); otherwise remember
    // the latest redirect until the delay slot is handed off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_address  <= RESET_VECTOR;
            pending        <= 1'b0;
            pending_target <= 32'd0;
        end else if (advance) begin
            fetch_address <= next_address;
            pending       <= 1'b0;
        end else if (redirect_valid) begin
            pending        <= 1'b1;
            pending_target <= word_align(redirect_target);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, reads instruction memory one word at
// a time and hands each word to decode over valid/ready, honouring branch
// delay slots and halting after a redirect to address 0.
// Optional: INSTRUCTION_FETCH_BYPASS_EN forwards the read data straight to
// decode in the completing cycle for one instruction per cycle.
module instruction_fetch_unit
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);

    fetch_state_t                 state;
    fetch_state_t                 next_state;
    logic [INSTRUCTION_WIDTH-1:0] instruction_q;
    logic [31:0]                  pc_q;
    logic [31:0]                  fetch_address;
    logic                         halt_next;
    logic                         read_done;
    logic                         valid;
    logic                         handoff;
    logic                         capture;
    logic                         redirect_valid;

    assign read_done      = (state == FETCH) && !bus.avm_waitrequest;
    assign handoff        = valid && bus.instruction_ready;
    assign redirect_valid = bus.redirect && ((state == FETCH) || (state == HOLD));

`ifdef INSTRUCTION_FETCH_BYPASS_EN
    assign valid               = (state == HOLD) || read_done;
    assign bus.instruction     = read_done ? bus.avm_readdata : instruction_q;
    assign bus.program_counter = read_done ? fetch_address : pc_q;
`else
    assign valid               = (state == HOLD);
    assign bus.instruction     = instruction_q;
    assign bus.program_counter = pc_q;
`endif

    assign bus.instruction_valid = valid;
    assign bus.avm_read          = (state == FETCH);
    assign bus.avm_address       = fetch_address;
    assign bus.active            = (state != HALTED);

    fetch_pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk             (clk),
        .reset           (reset),
        .advance         (handoff),
        .redirect_valid  (redirect_valid),
        .redirect_target (bus.redirect_target),
        .fetch_address   (fetch_address),
        .halt_next       (halt_next)
    );

    // State register; reset drops avm_read immediately and abandons any read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= START;
        else       state <= next_state;
    end

    // Next state and capture enable; a handoff in FETCH only happens with bypass.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            START:  next_state = FETCH;
            FETCH: begin
                if (read_done) begin
                    if (handoff) begin
                        next_state = halt_next ? HALTED : FETCH;
                    end else begin
                        next_state = HOLD;
                        capture    = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (handoff) next_state = halt_next ? HALTED : FETCH;
            end
            HALTED: next_state = HALTED;
            default: next_state = START;
        endcase
    end

    // Output register holding the word and its address until decode takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction_q <= '0;
            pc_q          <= RESET_VECTOR;
        end else if (capture) begin
            instruction_q <= bus.avm_readdata;
            pc_q          <= fetch_address;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run against a program-order reference model.
module tb_instruction_fetch_unit;
    import mips_cpu_pkg::*;

    localparam logic [31:0] RV = 32'hBFC0_0000;
`ifdef INSTRUCTION_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int GAP = BYP ? 1 : 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int stall_left = 0;
    logic [31:0] stall_addr = 32'd0;
    int wait_pct = 0;

    logic s_read, s_valid, s_active, s_hand, s_done, s_wait;
    logic [31:0] s_addr, s_instr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    // One clock: memory decides stall, inputs driven after the edge, outputs sampled at negedge.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] tgt);
        logic w;
        @(posedge clk);
        #1;
        if (stall_left > 0 && bus.avm_read && bus.avm_address == stall_addr) begin
            w = 1'b1;
            stall_left--;
        end else begin
            w = ($urandom_range(0, 99) < wait_pct);
        end
        bus.avm_waitrequest   = w;
        bus.avm_readdata      = w ? 32'hDEAD_BEEF : mem_word(bus.avm_address);
        bus.instruction_ready = rdy;
        bus.redirect          = rd;
        bus.redirect_target   = tgt;
        @(negedge clk);
        s_read   = bus.avm_read;
        s_addr   = bus.avm_address;
        s_valid  = bus.instruction_valid;
        s_instr  = bus.instruction;
        s_pc     = bus.program_counter;
        s_active = bus.active;
        s_wait   = w;
        s_done   = s_read & ~w;
        s_hand   = s_valid & rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'd0;
        bus.instruction_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'd0;
        stall_left = 0;
        wait_pct = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        int got;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'd0;
        bus.instruction_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_target = 32'd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.avm_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b want 0", bus.avm_read); end
        n_checks++; if (bus.avm_address !== RV) begin n_errors++; $display("FAIL reset_addr: got %h want %h", bus.avm_address, RV); end
        n_checks++; if (bus.instruction !== 32'd0) begin n_errors++; $display("FAIL reset_instr: got %h want 0", bus.instruction); end
        n_checks++; if (bus.instruction_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.instruction_valid); end
        n_checks++; if (bus.program_counter !== RV) begin n_errors++; $display("FAIL reset_pc: got %h want %h", bus.program_counter, RV); end
        n_checks++; if (bus.active !== 1'b1) begin n_errors++; $display("FAIL reset_active: got %b want 1", bus.active); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.avm_read !== 1'b0) begin n_errors++; $display("FAIL start_idle: got %b want 0", bus.avm_read); end
        // Reset while a read is stalled.
        stall_addr = RV;
        stall_left = 10;
        cycle(1'b1, 1'b0, 32'd0);
        n_checks++; if (s_read !== 1'b1 || s_addr !== RV) begin n_errors++; $display("FAIL stalled_read: got %b/%h want 1/%h", s_read, s_addr, RV); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (bus.avm_read !== 1'b0) begin n_errors++; $display("FAIL async_drop: got %b want 0", bus.avm_read); end
        @(posedge clk);
        #1 reset = 1'b0;
        stall_left = 0;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (s_hand) begin
                got = 1;
                n_checks++; if (s_pc !== RV || s_instr !== mem_word(RV)) begin n_errors++; $display("FAIL restart_first: got %h/%h want %h/%h", s_pc, s_instr, RV, mem_word(RV)); end
            end
        end
        n_checks++; if (got != 1) begin n_errors++; $display("FAIL restart_timeout: got %0d handoffs want 1", got); end
    endtask

    task automatic test_sequential();
        int nh, nf, last_h;
        nh = 0; nf = 0; last_h = -1;
        do_reset();
        for (int c = 0; c < 20 && nh < 3; c++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (c == 0) begin
                n_checks++; if (s_read !== 1'b1 || s_addr !== RV) begin n_errors++; $display("FAIL first_read: got %b/%h want 1/%h", s_read, s_addr, RV); end
            end
            if (s_done) begin
                n_checks++; if (s_addr !== RV + 32'(4 * nf)) begin n_errors++; $display("FAIL seq_fetch_addr: got %h want %h", s_addr, RV + 32'(4 * nf)); end
                nf++;
            end
            if (s_hand) begin
                n_checks++; if (s_pc !== RV + 32'(4 * nh)) begin n_errors++; $display("FAIL seq_pc: got %h want %h", s_pc, RV + 32'(4 * nh)); end
                n_checks++; if (s_instr !== mem_word(RV + 32'(4 * nh))) begin n_errors++; $display("FAIL seq_instr: got %h want %h", s_instr, mem_word(RV + 32'(4 * nh))); end
                if (last_h >= 0) begin
                    n_checks++; if (c - last_h != GAP) begin n_errors++; $display("FAIL seq_rate: got %0d cycles want %0d", c - last_h, GAP); end
                end
                if (BYP) begin
                    n_checks++; if (s_done !== 1'b1 || s_instr !== bus.avm_readdata) begin n_errors++; $display("FAIL bypass_same_cycle: got %b/%h want 1/%h", s_done, s_instr, bus.avm_readdata); end
                end
                last_h = c;
                nh++;
            end
        end
        n_checks++; if (nh != 3) begin n_errors++; $display("FAIL seq_timeout: got %0d handoffs want 3", nh); end
    endtask

    task automatic test_waitrequest();
        int nh, reads04, hits04;
        logic prev_stall;
        logic [31:0] prev_addr;
        nh = 0; reads04 = 0; hits04 = 0; prev_stall = 1'b0; prev_addr = 32'd0;
        do_reset();
        stall_addr = RV + 32'd4;
        stall_left = 3;
        for (int c = 0; c < 40 && nh < 3; c++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (prev_stall) begin
                n_checks++; if (s_read !== 1'b1 || s_addr !== prev_addr) begin n_errors++; $display("FAIL wait_stable: got %b/%h want 1/%h", s_read, s_addr, prev_addr); end
            end
            if (s_read && s_addr == RV + 32'd4) reads04++;
            if (s_hand) begin
                n_checks++; if (s_pc !== RV + 32'(4 * nh) || s_instr !== mem_word(RV + 32'(4 * nh))) begin n_errors++; $display("FAIL wait_deliver: got %h/%h want %h/%h", s_pc, s_instr, RV + 32'(4 * nh), mem_word(RV + 32'(4 * nh))); end
                if (s_pc == RV + 32'd4) hits04++;
                nh++;
            end
            prev_stall = s_read & s_wait;
            prev_addr = s_addr;
        end
        n_checks++; if (reads04 != 4) begin n_errors++; $display("FAIL wait_read_cycles: got %0d want 4", reads04); end
        n_checks++; if (hits04 != 1) begin n_errors++; $display("FAIL wait_delivered_once: got %0d want 1", hits04); end
        n_checks++; if (nh != 3) begin n_errors++; $display("FAIL wait_timeout: got %0d handoffs want 3", nh); end
    endtask

    task automatic test_ready_stall();
        int got;
        got = 0;
        do_reset();
        cycle(1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 32'd0);
            n_checks++;
            if (s_valid !== 1'b1 || s_instr !== mem_word(RV) || s_pc !== RV || s_read !== 1'b0) begin
                n_errors++;
                $display("FAIL ready_hold: got v=%b i=%h pc=%h rd=%b want v=1 i=%h pc=%h rd=0", s_valid, s_instr, s_pc, s_read, mem_word(RV), RV);
            end
        end
        cycle(1'b1, 1'b0, 32'd0);
        n_checks++; if (s_hand !== 1'b1 || s_pc !== RV) begin n_errors++; $display("FAIL ready_release: got %b/%h want 1/%h", s_hand, s_pc, RV); end
        for (int c = 0; c < 6 && got == 0; c++) begin
            cycle(1'b1, 1'b0, 32'd0);
            if (c == 0) begin
                n_checks++; if (s_read !== 1'b1 || s_addr !== RV + 32'd4) begin n_errors++; $display("FAIL ready_next_read: got %b/%h want 1/%h", s_read, s_addr, RV + 32'd4); end
            end
            if (s_hand) begin
                got = 1;
                n_checks++; if (s_pc !== RV + 32'd4) begin n_errors++; $display("FAIL ready_resume: got %h want %h", s_pc, RV + 32'd4); end
            end
        end
        n_checks++; if (got != 1) begin n_errors++; $display("FAIL ready_timeout: got %0d want 1", got); end
    endtask

    task automatic test_branch(input bit same_cycle);
        logic [31:0] exp [6];
        logic [31:0] tgt;
        int nh, nf, hb, off;
        logic rd;
        exp[0] = RV; exp[1] = RV + 32'h4; exp[2] = RV + 32'h8;
        exp[3] = RV + 32'hC; exp[4] = RV + 32'h100; exp[5] = RV + 32'h104;
        tgt = same_cycle ? RV + 32'h103 : RV + 32'h100;
        off = same_cycle ? GAP : 1;
        nh = 0; nf = 0; hb = -100;
        do_reset();
        for (int c = 0; c < 40 && nh < 6; c++) begin
            rd = (c == hb + off);
            cycle(1'b1, rd, rd ? tgt : 32'd0);
            if (s_done && nf < 6) begin
                n_checks++; if (s_addr !== exp[nf]) begin n_errors++; $display("FAIL branch_fetch: got %h want %h", s_addr, exp[nf]); end
                nf++;
            end
            if (s_hand) begin
                n_checks++; if (s_pc !== exp[nh] || s_instr !== mem_word(exp[nh])) begin n_errors++; $display("FAIL branch_deliver: got %h/%h want %h/%h", s_pc, s_instr, exp[nh], mem_word(exp[nh])); end
                if (exp[nh] == RV + 32'h8) hb = c;
                nh++;
            end
        end
        n_checks++; if (nh != 6) begin n_errors++; $display("FAIL branch_timeout: got %0d handoffs want 6", nh); end
    endtask

    task automatic test_halt();
        int nh, hb;
        logic halted, rd;
        nh = 0; hb = -100; halted = 1'b0;
        do_reset();
        for (int c = 0; c < 40 && !halted; c++) begin
            rd = (c == hb + 1);
            cycle(1'b1, rd, 32'd0);
            if (s_read && s_addr == 32'd0) begin
                n_checks++; n_errors++; $display("FAIL halt_read_zero: got read at %h want none", s_addr);
            end
            if (s_hand) begin
                n_checks++; if (s_pc !== RV + 32'(4 * nh)) begin n_errors++; $display("FAIL halt_deliver: got %h want %h", s_pc, RV + 32'(4 * nh)); end
                if (s_pc == RV + 32'd4) hb = c;
                nh++;
            end
            if (!s_active) halted = 1'b1;
        end
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_timeout: got active=1 want 0"); end
        n_checks++; if (nh != 3) begin n_errors++; $display("FAIL halt_delay_slot: got %0d handoffs want 3", nh); end
        for (int c = 0; c < 20; c++) begin
            cycle(1'b1, 1'b1, RV);
            n_checks++;
            if (s_read !== 1'b0 || s_valid !== 1'b0 || s_active !== 1'b0) begin
                n_errors++;
                $display("FAIL halted_idle: got rd=%b v=%b act=%b want 0/0/0", s_read, s_valid, s_active);
            end
        end
        do_reset();
        cycle(1'b1, 1'b0, 32'd0);
        n_checks++; if (s_read !== 1'b1 || s_addr !== RV || s_active !== 1'b1) begin n_errors++; $display("FAIL halt_restart: got %b/%h/%b want 1/%h/1", s_read, s_addr, s_active, RV); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [6];
        int nh, hb;
        logic rd;
        exp[0] = RV; exp[1] = RV + 32'h4; exp[2] = 32'hFFFF_FFF8;
        exp[3] = 32'hFFFF_FFFC; exp[4] = 32'h0000_0000; exp[5] = 32'h0000_0004;
        nh = 0; hb = -100;
        do_reset();
        for (int c = 0; c < 40 && nh < 6; c++) begin
            rd = (c == hb + 1);
            cycle(1'b1, rd, 32'hFFFF_FFFB);
            n_checks++; if (s_active !== 1'b1) begin n_errors++; $display("FAIL wrap_active: got %b want 1", s_active); end
            if (s_hand) begin
                n_checks++; if (s_pc !== exp[nh] || s_instr !== mem_word(exp[nh])) begin n_errors++; $display("FAIL wrap_deliver: got %h/%h want %h/%h", s_pc, s_instr, exp[nh], mem_word(exp[nh])); end
                if (nh == 0) hb = c;
                nh++;
            end
        end
        n_checks++; if (nh != 6) begin n_errors++; $display("FAIL wrap_timeout: got %0d handoffs want 6", nh); end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, ptgt, tgt, prev_addr, prev_instr, prev_pc;
        logic pend, rdy, rd, prev_stall, prev_held;
        int nh;
        exp_pc = RV; pend = 1'b0; ptgt = 32'd0; nh = 0;
        prev_stall = 1'b0; prev_held = 1'b0;
        prev_addr = 32'd0; prev_instr = 32'd0; prev_pc = 32'd0;
        do_reset();
        wait_pct = 30;
        for (int c = 0; c < 600; c++) begin
            rdy = ($urandom_range(0, 99) < 70);
            rd  = (nh > 0) && ($urandom_range(0, 99) < 10);
            tgt = $urandom | 32'h0000_1000;
            cycle(rdy, rd, tgt);
            if (prev_stall) begin
                n_checks++; if (s_read !== 1'b1 || s_addr !== prev_addr) begin n_errors++; $display("FAIL rnd_stall_stable: got %b/%h want 1/%h", s_read, s_addr, prev_addr); end
            end
            if (prev_held) begin
                n_checks++;
                if (s_read !== 1'b0 || s_valid !== 1'b1 || s_instr !== prev_instr || s_pc !== prev_pc) begin
                    n_errors++;
                    $display("FAIL rnd_hold_stable: got rd=%b v=%b %h/%h want 0/1 %h/%h", s_read, s_valid, s_instr, s_pc, prev_instr, prev_pc);
                end
            end
            if (s_done) begin
                n_checks++; if (s_addr !== exp_pc) begin n_errors++; $display("FAIL rnd_fetch_addr: got %h want %h", s_addr, exp_pc); end
            end
            if (s_hand) begin
                n_checks++; if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc)) begin n_errors++; $display("FAIL rnd_deliver: got %h/%h want %h/%h", s_pc, s_instr, exp_pc, mem_word(exp_pc)); end
                if (rd)        exp_pc = {tgt[31:2], 2'b00};
                else if (pend) exp_pc = ptgt;
                else           exp_pc = exp_pc + 32'd4;
                pend = 1'b0;
                nh++;
            end else if (rd) begin
                pend = 1'b1;
                ptgt = {tgt[31:2], 2'b00};
            end
            prev_stall = s_read & s_wait;
            prev_held  = s_valid & ~s_hand;
            prev_addr  = s_addr;
            prev_instr = s_instr;
            prev_pc    = s_pc;
        end
        wait_pct = 0;
        n_checks++; if (nh < 50) begin n_errors++; $display("FAIL rnd_progress: got %0d handoffs want >=50", nh); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_waitrequest();
        test_ready_stall();
        test_branch(1'b0);
        test_branch(1'b1);
        test_halt();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that produces the 32-bit instruction words consumed by the decode/control logic. It owns the program counter and reads instruction memory over the CPU's Avalon-style read bus with `waitrequest`. It hands each instruction to decode through a valid/ready handshake. It applies branch/jump redirects with MIPS delay-slot semantics and stops fetching after a jump to address 0.

## Interface
Parameters:
- `RESET_VECTOR`, default `32'hBFC0_0000`: address of the first fetch after reset.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `avm_address`  out  32  fetch address; word-aligned, bits [1:0] always 0.
- `avm_read`  out  1  read request; held with a stable address until `avm_waitrequest` is low.
- `avm_waitrequest`  in  1  memory stall; a read completes in a cycle with `avm_read=1`, `avm_waitrequest=0`.
- `avm_readdata`  in  32  instruction word; valid in the completing cycle.
- `instruction`  out  32  instruction word presented to decode.
- `instruction_valid`  out  1  `instruction` and `program_counter` are valid.
- `instruction_ready`  in  1  decode accepts; handoff = `instruction_valid & instruction_ready`.
- `program_counter`  out  32  address of the presented instruction.
- `redirect`  in  1  one-cycle pulse from branch/jump resolution.
- `redirect_target`  in  32  new PC, sampled with `redirect`; bits [1:0] ignored.
- `active`  out  1  high while the core is running; low once halted.

## Operation
- States: `START`, `FETCH`, `HOLD`, `HALTED`.
- `START`: idle for one cycle after reset deasserts, then go to `FETCH` with fetch address `RESET_VECTOR`.
- `FETCH`: drive `avm_read=1` and the fetch address. On completion, capture `avm_readdata` and the fetch address into the output register, then go to `HOLD`.
- `HOLD`: drive `instruction_valid=1`. On handoff of the instruction at address A, compute the next fetch address:
  - if a redirect is pending: `redirect_target`, and clear the pending flag;
  - otherwise: A+4, with 32-bit wrap, so `FFFF_FFFC` goes to `0000_0000`.
  - Then go to `FETCH`, or to `HALTED` if the next address is 0 and was reached by redirect.
- Delay slot:
  - `redirect` is asserted for branch B after B has been handed off, while B+4 is being fetched or held.
  - The pending target is applied on the handoff of B+4, so the delay slot always executes.
- `redirect` arriving in the same cycle as a handoff applies to that handoff.
- A second `redirect` while one is pending overwrites the target.
- `redirect` in `START` or `HALTED` is ignored.
- `HALTED`: `avm_read=0`, `instruction_valid=0`, `active=0`; leave only by reset.
- Sequential wrap to 0 does not halt.
- At most one read is outstanding; no prefetch beyond one instruction.

## Timing
- Reset values:
  - `avm_read=0`, `avm_address=RESET_VECTOR`
  - `instruction=0`, `instruction_valid=0`, `program_counter=RESET_VECTOR`
  - `active=1`, no redirect pending, state `START`.
- Reset asserted mid-read: `avm_read` drops immediately (asynchronous) and the in-flight data is discarded.
- First `avm_read=1` occurs 1 cycle after reset deasserts.
- Registered path: read completes in cycle N → `instruction_valid=1` in N+1.
- Handoff in cycle M → next `avm_read=1` in M+1.
- `avm_address` never changes while `avm_read=1 & avm_waitrequest=1`.
- `instruction` and `program_counter` are stable while `instruction_valid=1` and not handed off.

## Configuration
- `INSTRUCTION_FETCH_BYPASS_EN`:
  - Defined:
    - In the completing `FETCH` cycle, `instruction=avm_readdata` and `instruction_valid=1` combinationally, with `program_counter` = fetch address.
    - If `instruction_ready=1` in that cycle, the handoff occurs then and the state stays `FETCH` with the next address in the following cycle.
    - Otherwise the word is captured and the state goes to `HOLD`.
    - Single-cycle memory with ready tied high gives one instruction per cycle.
  - Undefined: registered path only; minimum 2 cycles per instruction.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - the `fetch_state_t` enum (`START`, `FETCH`, `HOLD`, `HALTED`);
  - the `RESET_VECTOR` default;
  - `INSTRUCTION_WIDTH=32`.
- One sub-module is natural: `fetch_pc_register`. It holds the fetch address, pending flag and pending target, and computes the next address. The state machine and output register stay in the top module.

## Test plan
- Reset, zero-wait memory, ready high: fetch addresses `BFC00000, BFC00004, BFC00008`; `program_counter` matches each delivered instruction; first `avm_read` 1 cycle after reset release.
- `avm_waitrequest` high for 3 cycles at `BFC00004`: address and `avm_read` stable for 4 cycles; correct word delivered once.
- `instruction_ready` low for 5 cycles: `instruction` held constant, no new read issued, resumes at +4 after handoff.
- Branch at `BFC00008` handed off, `redirect` with target `BFC00100` during fetch of `BFC0000C`: `BFC0000C` delivered, next fetch `BFC00100`; repeat with redirect on the handoff cycle itself, same result.
- Redirect to `00000000` after delay slot: delay slot delivered, then `active=0`, `avm_read` stays 0 for 20 cycles; reset restarts at `RESET_VECTOR`.
- With `INSTRUCTION_FETCH_BYPASS_EN`, zero-wait memory, ready high: one handoff per cycle, `instruction` equals `avm_readdata` in the same cycle.
